lsu_mem_writeback: RTL and testbench
====================================

Name: lsu_mem_writeback

Overview:
- Downstream consumer of the load/store queue.
- Accepts each retired queue entry on its one-cycle done pulse and buffers it in a small pending FIFO.
- Performs the 8-lane memory access one lane per cycle on a single-port data memory.
- For loads, writes all 8 lanes back to the warp's register file in one commit cycle. For every op, signals completion to the warp scheduler so it can clear the scoreboard.

Parameters:
- DATA_WIDTH, 16, width of one lane's data word.
- ADDR_WIDTH, 8, width of one lane's memory address.
- PEND_DEPTH, 4, pending-entry FIFO depth; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  one-cycle pulse from the queue (its done bit); entry fields valid this cycle.
- in_is_store  input  1  0 = load, 1 = store.
- in_warp  input  2  warp number.
- in_dest  input  4  destination register (loads).
- in_addr  input  ADDR_WIDTH x 8  per-lane address, unpacked array [7:0].
- in_st_data  input  DATA_WIDTH x 8  per-lane store data, unpacked array [7:0]; ignored for loads.
- mem_req  output  1  memory access this cycle.
- mem_we  output  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  output  ADDR_WIDTH  access address.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_rdata  input  DATA_WIDTH  read data; valid exactly 1 cycle after a read request.
- rf_we  output  1  register-file write strobe, one cycle.
- rf_warp  output  2  warp of the RF write.
- rf_dest  output  4  register of the RF write.
- rf_wdata  output  DATA_WIDTH x 8  per-lane load result, unpacked [7:0].
- done_valid  output  1  one-cycle completion pulse to the scheduler.
- done_warp  output  2  warp of the completed op.
- done_is_store  output  1  type of the completed op.
- busy  output  1  FSM not IDLE or FIFO non-empty.
- overflow  output  1  sticky: an in_valid was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous):
  - FIFO empty; FSM to IDLE; lane counter 0; overflow 0.
  - All outputs 0, including rf_wdata and the data capture buffer.
  - Reset mid-operation abandons the op; no further mem_req, rf_we or done_valid is issued for it.
- FIFO:
  - On in_valid with FIFO not full, the entry (all fields) is pushed at that edge.
  - On in_valid with FIFO full, the entry is dropped and overflow is set; overflow clears only on reset.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - A pop in the same cycle frees a slot only for the next cycle: full is evaluated on the registered count.
  - Pointers wrap modulo PEND_DEPTH.
- FSM states: IDLE, LANE, DRAIN, COMMIT.
- IDLE:
  - If the FIFO is non-empty, pop the head into the op register, clear the lane counter, and go to LANE.
  - An entry pushed in cycle N is seen non-empty in cycle N+1.
- LANE:
  - Each cycle: mem_req=1, mem_we=op.is_store, mem_addr=op.addr[lane], mem_wdata=op.st_data[lane] (0 for loads); then lane increments.
  - For a load, mem_rdata is captured into buf[lane-1] for every lane>0 cycle.
  - After lane 7: a load goes to DRAIN; a store goes to COMMIT.
- DRAIN (loads only): mem_req=0; capture mem_rdata into buf[7]; go to COMMIT.
- COMMIT:
  - done_valid=1 with done_warp and done_is_store.
  - For loads, also rf_we=1 with rf_warp, rf_dest and rf_wdata=buf in the same cycle.
  - Always go to IDLE.
- Latency, in_valid in cycle 0 into an empty FIFO with the FSM in IDLE:
  - Pop in cycle 1.
  - mem_req in cycles 2–9.
  - Load: DRAIN in cycle 10; rf_we and done_valid in cycle 11.
  - Store: done_valid in cycle 10.
- Throughput: one op per 11 cycles (load) or 10 cycles (store), since each op passes through IDLE.
- Ops complete strictly in FIFO order.
- Duplicate addresses across lanes are legal; accesses are performed in lane order 0..7, so the last lane's write wins.
- Outputs are combinational from the registered state and op register.
- mem_req, rf_we and done_valid are 0 in every cycle not listed above.

Test Plan:
- Single load, warp 2, dest 5, addr[i]=0x10+i, memory model returns 0x1000+addr → mem_req in cycles 2–9 with addresses 0x10..0x17; cycle 11: rf_we=1, rf_warp=2, rf_dest=5, rf_wdata[i]=0x1010+i, done_valid=1, done_is_store=0.
- Single store, warp 1, addr[i]=0x40+i, st_data[i]=0xA0+i → cycles 2–9 mem_we=1 with the matching addr/data; cycle 10: done_valid=1, done_is_store=1, rf_we stays 0 throughout.
- Four load pulses on consecutive cycles → all accepted, overflow=0; four completions in push order, at cycles 11, 22, 33, 44.
- Pulses in cycles 0,1,2,3,4,5 with PEND_DEPTH=4 (one pop at cycle 1) → cycle-5 entry dropped, overflow=1 and held; exactly five completions; busy deasserts after the last.
- Reset asserted in cycle 6 of a load → cycle 7 onward: all outputs 0, no rf_we/done_valid for that op; a new load issued afterwards completes with normal 11-cycle latency.
- Load with addr[3]=addr[6]=0x22 after a prior store of 0x5A5A to 0x22 → rf_wdata[3]=rf_wdata[6]=0x5A5A.

Source files
------------

// File: rtl/lsu_mem_writeback.sv
// lsu_mem_writeback: buffers retired load/store queue entries in a small FIFO,
// walks the 8 lanes one per cycle on a single-port data memory, then commits
// load results to the register file and signals completion to the scheduler.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting; pops the FIFO head into the op register when non-empty
// LANE   | one memory access per cycle, lanes 0..7 in order
// DRAIN  | loads only: capture the read data of lane 7
// COMMIT | done pulse to the scheduler; RF write for loads
module lsu_mem_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int PEND_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_is_store,
  input  logic [1:0]            in_warp,
  input  logic [3:0]            in_dest,
  input  logic [ADDR_WIDTH-1:0] in_addr    [7:0],
  input  logic [DATA_WIDTH-1:0] in_st_data [7:0],
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_we,
  output logic [1:0]            rf_warp,
  output logic [3:0]            rf_dest,
  output logic [DATA_WIDTH-1:0] rf_wdata   [7:0],
  output logic                  done_valid,
  output logic [1:0]            done_warp,
  output logic                  done_is_store,
  output logic                  busy,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(PEND_DEPTH);

  typedef enum logic [1:0] {IDLE, LANE, DRAIN, COMMIT} state_t;

  state_t state, next_state;

  // pending FIFO storage
  logic                  f_is_store [PEND_DEPTH];
  logic [1:0]            f_warp     [PEND_DEPTH];
  logic [3:0]            f_dest     [PEND_DEPTH];
  logic [ADDR_WIDTH-1:0] f_addr     [PEND_DEPTH][8];
  logic [DATA_WIDTH-1:0] f_data     [PEND_DEPTH][8];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  // op register and load capture buffer
  logic                  op_is_store;
  logic [1:0]            op_warp;
  logic [3:0]            op_dest;
  logic [ADDR_WIDTH-1:0] op_addr [8];
  logic [DATA_WIDTH-1:0] op_data [8];
  logic [DATA_WIDTH-1:0] cap_buf [8];
  logic [2:0]            lane;

  // full is taken from the registered count, so a same-cycle pop does not make room
  assign fifo_full  = (count == (PTR_W + 1)'(PEND_DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_push  = in_valid && !fifo_full;
  assign busy       = (state != IDLE) || !fifo_empty;

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && fifo_full) overflow <= 1'b1;
    end
  end

  // FIFO entry storage; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      f_is_store[wr_ptr] <= in_is_store;
      f_warp[wr_ptr]     <= in_warp;
      f_dest[wr_ptr]     <= in_dest;
      for (int i = 0; i < 8; i++) begin
        f_addr[wr_ptr][i] <= in_addr[i];
        f_data[wr_ptr][i] <= in_st_data[i];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // op register load on pop, lane counter and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      op_is_store <= 1'b0;
      op_warp     <= '0;
      op_dest     <= '0;
      lane        <= '0;
      for (int i = 0; i < 8; i++) begin
        op_addr[i] <= '0;
        op_data[i] <= '0;
        cap_buf[i] <= '0;
      end
    end else begin
      if (fifo_pop) begin
        op_is_store <= f_is_store[rd_ptr];
        op_warp     <= f_warp[rd_ptr];
        op_dest     <= f_dest[rd_ptr];
        lane        <= '0;
        for (int i = 0; i < 8; i++) begin
          op_addr[i] <= f_addr[rd_ptr][i];
          op_data[i] <= f_data[rd_ptr][i];
        end
      end
      if (state == LANE) begin
        lane <= lane + 1'b1;
        // read data of lane n-1 arrives while lane n is being issued
        if (!op_is_store && lane != 3'd0) cap_buf[lane - 3'd1] <= mem_rdata;
      end
      if (state == DRAIN) cap_buf[7] <= mem_rdata;
    end
  end

  // next-state and registered-state-derived outputs
  always_comb begin
    next_state    = state;
    fifo_pop      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rf_we         = 1'b0;
    rf_warp       = '0;
    rf_dest       = '0;
    done_valid    = 1'b0;
    done_warp     = '0;
    done_is_store = 1'b0;
    for (int i = 0; i < 8; i++) rf_wdata[i] = '0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = LANE;
        end
      end
      LANE: begin
        mem_req   = 1'b1;
        mem_we    = op_is_store;
        mem_addr  = op_addr[lane];
        mem_wdata = op_is_store ? op_data[lane] : '0;
        if (lane == 3'd7) next_state = op_is_store ? COMMIT : DRAIN;
      end
      DRAIN: begin
        next_state = COMMIT;
      end
      COMMIT: begin
        done_valid    = 1'b1;
        done_warp     = op_warp;
        done_is_store = op_is_store;
        if (!op_is_store) begin
          rf_we   = 1'b1;
          rf_warp = op_warp;
          rf_dest = op_dest;
          for (int i = 0; i < 8; i++) rf_wdata[i] = cap_buf[i];
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_writeback.sv
// Self-checking bench for lsu_mem_writeback. The reference model schedules
// each accepted op from its push cycle (pop when the unit is free, 8 access
// cycles, commit) and computes load results against a shadow memory applied
// in FIFO order. All bench state lives in the single initial process.
module tb_lsu_mem_writeback;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PD = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, in_is_store;
  logic [1:0]    in_warp;
  logic [3:0]    in_dest;
  logic [AW-1:0] in_addr    [7:0];
  logic [DW-1:0] in_st_data [7:0];
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          rf_we;
  logic [1:0]    rf_warp;
  logic [3:0]    rf_dest;
  logic [DW-1:0] rf_wdata [7:0];
  logic          done_valid;
  logic [1:0]    done_warp;
  logic          done_is_store, busy, overflow;

  lsu_mem_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PEND_DEPTH(PD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_is_store(in_is_store),
    .in_warp(in_warp), .in_dest(in_dest), .in_addr(in_addr), .in_st_data(in_st_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_warp(rf_warp), .rf_dest(rf_dest),
    .rf_wdata(rf_wdata), .done_valid(done_valid), .done_warp(done_warp),
    .done_is_store(done_is_store), .busy(busy), .overflow(overflow)
  );

  typedef struct packed {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct packed {
    int              cyc;
    logic [1:0]      warp;
    logic            st;
    logic [3:0]      dest;
    logic [8*DW-1:0] data;
  } cmp_t;

  acc_t acc_q[$];
  cmp_t cmp_q[$];
  int   push_l[$], pop_l[$], commit_l[$];
  int   last_commit, ovf_from, cyc, checks, errors, rf_we_cnt;
  bit   mon_en;
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  int            done_cyc_q[$];
  logic [8*DW-1:0] done_dat_q[$];
  logic          s_req, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  task model_clear();
    acc_q.delete(); cmp_q.delete();
    push_l.delete(); pop_l.delete(); commit_l.delete();
    last_commit = -100;
    ovf_from    = -1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
  endtask

  task model_issue(input int c, input bit st, input logic [1:0] w, input logic [3:0] dst,
                   input logic [8*AW-1:0] a, input logic [8*DW-1:0] d);
    int occ, pop, com;
    cmp_t e;
    acc_t x;
    logic [AW-1:0] ad;
    occ = 0;
    foreach (push_l[i]) if (push_l[i] < c && pop_l[i] >= c) occ++;
    if (occ >= PD) begin
      if (ovf_from < 0) ovf_from = c + 1;
      return;
    end
    pop = (c + 1 > last_commit + 1) ? c + 1 : last_commit + 1;
    com = pop + (st ? 9 : 10);
    last_commit = com;
    push_l.push_back(c); pop_l.push_back(pop); commit_l.push_back(com);
    e.cyc = com; e.warp = w; e.st = st; e.dest = dst; e.data = '0;
    for (int l = 0; l < 8; l++) begin
      ad = a[l*AW +: AW];
      x.cyc = pop + 1 + l; x.we = st; x.addr = ad;
      x.wdata = st ? d[l*DW +: DW] : '0;
      if (st) ref_mem[ad] = d[l*DW +: DW];
      else    e.data[l*DW +: DW] = ref_mem[ad];
      acc_q.push_back(x);
    end
    cmp_q.push_back(e);
  endtask

  task monitor();
    acc_t x;
    cmp_t e;
    logic [8*DW-1:0] obs;
    bit exp_busy, exp_ovf;
    if (!mon_en) return;
    checks++;
    if (mem_req) begin
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL mem_spurious cyc=%0d got we=%b addr=%h, required no request", cyc, mem_we, mem_addr);
      end else begin
        x = acc_q.pop_front();
        if (x.cyc != cyc || mem_we !== x.we || mem_addr !== x.addr || mem_wdata !== x.wdata) begin
          errors++;
          $display("FAIL mem_access cyc=%0d got we=%b addr=%h wdata=%h, required cyc=%0d we=%b addr=%h wdata=%h",
                   cyc, mem_we, mem_addr, mem_wdata, x.cyc, x.we, x.addr, x.wdata);
        end
      end
    end else if (acc_q.size() != 0 && acc_q[0].cyc <= cyc) begin
      errors++;
      x = acc_q.pop_front();
      $display("FAIL mem_missing cyc=%0d got no request, required addr=%h", cyc, x.addr);
    end

    checks++;
    if (done_valid || rf_we) begin
      for (int i = 0; i < 8; i++) obs[i*DW +: DW] = rf_wdata[i];
      done_cyc_q.push_back(cyc);
      done_dat_q.push_back(obs);
      if (rf_we) rf_we_cnt++;
      if (cmp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_spurious cyc=%0d got done=%b rf_we=%b, required none", cyc, done_valid, rf_we);
      end else begin
        e = cmp_q.pop_front();
        if (e.cyc != cyc || done_valid !== 1'b1 || done_warp !== e.warp ||
            done_is_store !== e.st || rf_we !== !e.st) begin
          errors++;
          $display("FAIL commit_ctrl cyc=%0d got done=%b warp=%0d st=%b rf_we=%b, required cyc=%0d warp=%0d st=%b",
                   cyc, done_valid, done_warp, done_is_store, rf_we, e.cyc, e.warp, e.st);
        end else if (!e.st && (rf_warp !== e.warp || rf_dest !== e.dest || obs !== e.data)) begin
          errors++;
          $display("FAIL commit_data cyc=%0d got warp=%0d dest=%0d data=%h, required warp=%0d dest=%0d data=%h",
                   cyc, rf_warp, rf_dest, obs, e.warp, e.dest, e.data);
        end
      end
    end else if (cmp_q.size() != 0 && cmp_q[0].cyc <= cyc) begin
      errors++;
      e = cmp_q.pop_front();
      $display("FAIL commit_missing cyc=%0d got no done, required at cyc=%0d", cyc, e.cyc);
    end

    exp_ovf = (ovf_from >= 0) && (cyc >= ovf_from);
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow cyc=%0d got %b, required %b", cyc, overflow, exp_ovf);
    end

    exp_busy = 1'b0;
    foreach (push_l[i]) if (push_l[i] < cyc && commit_l[i] >= cyc) exp_busy = 1'b1;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got %b, required %b", cyc, busy, exp_busy);
    end
  endtask

  // one clock: check at the falling edge, then memory model and new cycle after the rising edge
  task step();
    @(negedge clk);
    monitor();
    s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge clk);
    #1;
    cyc++;
    if (s_req && s_we) mem[s_addr] = s_wdata;
    if (s_req && !s_we) mem_rdata = mem[s_addr];
    else                mem_rdata = DW'($urandom);
  endtask

  task issue(input bit st, input logic [1:0] w, input logic [3:0] dst,
             input logic [8*AW-1:0] a, input logic [8*DW-1:0] d);
    in_valid = 1'b1; in_is_store = st; in_warp = w; in_dest = dst;
    for (int i = 0; i < 8; i++) begin
      in_addr[i]    = a[i*AW +: AW];
      in_st_data[i] = d[i*DW +: DW];
    end
    model_issue(cyc, st, w, dst, a, d);
    step();
    in_valid = 1'b0; in_is_store = 1'($urandom); in_warp = 2'($urandom); in_dest = 4'($urandom);
    for (int i = 0; i < 8; i++) begin
      in_addr[i]    = AW'($urandom);
      in_st_data[i] = DW'($urandom);
    end
  endtask

  task wait_drain(input int limit);
    for (int n = 0; n < limit; n++) begin
      if (cmp_q.size() == 0 && acc_q.size() == 0) break;
      step();
    end
    step(); step();
    checks++;
    if (cmp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending completions, required 0", cmp_q.size());
      cmp_q.delete(); acc_q.delete();
    end
  endtask

  task pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
  endtask

  task check_all_zero(input string tag);
    bit nz;
    nz = mem_req | mem_we | (|mem_addr) | (|mem_wdata) | rf_we | (|rf_warp) | (|rf_dest) |
         done_valid | (|done_warp) | done_is_store | busy | overflow;
    for (int i = 0; i < 8; i++) nz = nz | (|rf_wdata[i]);
    checks++;
    if (nz !== 1'b0) begin
      errors++;
      $display("FAIL %s cyc=%0d got nonzero outputs (req=%b rf_we=%b done=%b busy=%b ovf=%b), required all 0",
               tag, cyc, mem_req, rf_we, done_valid, busy, overflow);
    end
  endtask

  task test_reset();
    repeat (2) step();
    check_all_zero("reset_outputs");
  endtask

  task test_single_load();
    logic [8*AW-1:0] a;
    logic [8*DW-1:0] d, got;
    int c;
    for (int i = 0; i < 8; i++) a[i*AW +: AW] = AW'(8'h10 + i);
    d = {4{32'($urandom)}};
    done_cyc_q.delete(); done_dat_q.delete();
    c = cyc;
    issue(1'b0, 2'd2, 4'd5, a, d);
    wait_drain(40);
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - c != 11) begin
      errors++;
      $display("FAIL load_latency got %0d completions first at +%0d, required 1 at +11",
               done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] - c : -1);
    end else begin
      got = done_dat_q[0];
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i*DW +: DW] !== DW'(16'h1010 + i)) begin
          errors++;
          $display("FAIL load_data lane %0d got %h, required %h", i, got[i*DW +: DW], DW'(16'h1010 + i));
        end
      end
    end
  endtask

  task test_single_store();
    logic [8*AW-1:0] a;
    logic [8*DW-1:0] d;
    int c, rf0;
    for (int i = 0; i < 8; i++) begin
      a[i*AW +: AW] = AW'(8'h40 + i);
      d[i*DW +: DW] = DW'(16'hA0 + i);
    end
    done_cyc_q.delete(); done_dat_q.delete();
    rf0 = rf_we_cnt;
    c = cyc;
    issue(1'b1, 2'd1, 4'($urandom), a, d);
    wait_drain(40);
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - c != 10 || rf_we_cnt != rf0) begin
      errors++;
      $display("FAIL store_latency got %0d completions first at +%0d rf_we=%0d, required 1 at +10 rf_we=0",
               done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] - c : -1, rf_we_cnt - rf0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8'h40 + i] !== DW'(16'hA0 + i)) begin
        errors++;
        $display("FAIL store_mem lane %0d got %h, required %h", i, mem[8'h40 + i], DW'(16'hA0 + i));
      end
    end
  endtask

  task test_back_to_back();
    logic [8*AW-1:0] a;
    logic [8*DW-1:0] d;
    int c;
    done_cyc_q.delete(); done_dat_q.delete();
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) a[i*AW +: AW] = AW'($urandom);
      d = '0;
      issue(1'b0, 2'(k), 4'(k + 8), a, d);
    end
    wait_drain(80);
    checks++;
    if (done_cyc_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d, required 4", done_cyc_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (done_cyc_q[k] - c != 11 * (k + 1)) begin
          errors++;
          $display("FAIL b2b_cycle op %0d got +%0d, required +%0d", k, done_cyc_q[k] - c, 11 * (k + 1));
        end
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overflow got %b, required 0", overflow);
    end
  endtask

  task test_overflow();
    logic [8*AW-1:0] a;
    logic [8*DW-1:0] d;
    done_cyc_q.delete(); done_dat_q.delete();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) a[i*AW +: AW] = AW'($urandom);
      d = {4{32'($urandom)}};
      issue(1'b0, 2'(k), 4'(k), a, d);
    end
    wait_drain(100);
    repeat (5) step();
    checks++;
    if (done_cyc_q.size() != 5 || overflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drop got completions=%0d overflow=%b busy=%b, required 5 1 0",
               done_cyc_q.size(), overflow, busy);
    end
    pulse_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got %b, required 0", overflow);
    end
  endtask

  task test_reset_mid();
    logic [8*AW-1:0] a;
    logic [8*DW-1:0] d;
    int c;
    for (int i = 0; i < 8; i++) a[i*AW +: AW] = AW'($urandom);
    d = '0;
    done_cyc_q.delete(); done_dat_q.delete();
    c = cyc;
    issue(1'b0, 2'd3, 4'd9, a, d);
    while (cyc < c + 6) step();
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      check_all_zero("reset_mid_outputs");
      step();
    end
    c = cyc;
    issue(1'b0, 2'd1, 4'd2, a, d);
    wait_drain(40);
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - c != 11) begin
      errors++;
      $display("FAIL reset_mid_recover got %0d completions first at +%0d, required 1 at +11",
               done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] - c : -1);
    end
  endtask

  task test_dup_addr();
    logic [8*AW-1:0] a;
    logic [8*DW-1:0] d, got;
    for (int i = 0; i < 8; i++) begin
      a[i*AW +: AW] = AW'(8'h80 + i);
      d[i*DW +: DW] = DW'($urandom);
    end
    a[0 +: AW] = 8'h22;
    d[0 +: DW] = 16'h5A5A;
    issue(1'b1, 2'd0, 4'd0, a, d);
    for (int i = 0; i < 8; i++) a[i*AW +: AW] = AW'($urandom_range(8'h90, 8'hFF));
    a[3*AW +: AW] = 8'h22;
    a[6*AW +: AW] = 8'h22;
    done_cyc_q.delete(); done_dat_q.delete();
    issue(1'b0, 2'd2, 4'd7, a, '0);
    wait_drain(60);
    checks++;
    if (done_dat_q.size() < 2) begin
      errors++;
      $display("FAIL dup_count got %0d completions, required 2", done_dat_q.size());
    end else begin
      got = done_dat_q[1];
      checks++;
      if (got[3*DW +: DW] !== 16'h5A5A || got[6*DW +: DW] !== 16'h5A5A) begin
        errors++;
        $display("FAIL dup_data got lane3=%h lane6=%h, required 5a5a 5a5a", got[3*DW +: DW], got[6*DW +: DW]);
      end
    end
  endtask

  task test_random();
    logic [8*AW-1:0] a;
    logic [8*DW-1:0] d;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 8; i++) begin
        a[i*AW +: AW] = AW'($urandom_range(0, 31));
        d[i*DW +: DW] = DW'($urandom);
      end
      issue(1'($urandom), 2'($urandom), 4'($urandom), a, d);
      repeat ($urandom_range(0, 12)) step();
    end
    wait_drain(800);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; rf_we_cnt = 0; mon_en = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_warp = '0; in_dest = '0;
    for (int i = 0; i < 8; i++) begin
      in_addr[i] = '0;
      in_st_data[i] = '0;
    end
    for (int i = 0; i < 256; i++) mem[i] = DW'(16'h1000 + i);
    mem_rdata = '0;
    model_clear();
    step();
    test_reset();
    reset = 1'b0;
    model_clear();
    mon_en = 1'b1;
    test_single_load();
    test_single_store();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_dup_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
